adc_cfg_seq: RTL and testbench
==============================

ADC_CFG_SEQ -- requirements
Module: adc_cfg_seq

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 32, SCLK half-period in clk cycles (legal range 2..255).
REQ-002 The module SHALL have parameter RST_LEN, default 256, ADC reset pulse width in clk cycles.
REQ-003 The module SHALL have parameter RST_WAIT, default 1024, clk cycles from reset-pulse end to first frame.
REQ-004 Port: clk  in  1  system clock; one clock, all logic on posedge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: start  in  1  one-cycle pulse; runs the full init sequence.
REQ-007 Port: host_req / host_addr / host_data  in  1/8/8  runtime register-write request; addr and data are held stable while req is high.
REQ-008 Port: host_ack  out  1  one-cycle pulse; host frame accepted and latched.
REQ-009 Port: busy  out  1  high in every state except IDLE.
REQ-010 Port: init_done  out  1  level; set when the last init frame ends.
REQ-011 Port: adc_reset  out  1  ADC hardware reset, active-high.
REQ-012 Port: adc_sen / adc_sclk / adc_sdat  out  1/1/1  serial bus; sen active-low, shared by both ADCs.
REQ-013 Port: frame_cnt  out  8  count of completed frames, init and host frames combined.

Function
REQ-014 FSM states SHALL be IDLE, RST_PULSE, RST_WAIT, LOAD, SHIFT, GAP.
REQ-015 IDLE+start SHALL go to RST_PULSE; init_done cleared; adc_reset high for exactly RST_LEN cycles.
REQ-016 RST_PULSE end SHALL go to RST_WAIT; adc_reset low; RST_WAIT lasts RST_WAIT cycles, then LOAD with table index 0.
REQ-017 Init table SHALL be fixed: {0x00,0x02}, {0x3D,0xE0}, {0x41,0xC0}, {0x25,0x03}, sent in order.
REQ-018 LOAD SHALL take 1 cycle: latch {addr,data} into a 16-bit shift register, then go to SHIFT.
REQ-019 SHIFT: adc_sen low; 16 bits MSB first, address then data; per bit sclk low CLK_DIV cycles then high CLK_DIV cycles.
REQ-020 adc_sdat SHALL change only at the start of the sclk-low phase; frame length exactly 32*CLK_DIV cycles.
REQ-021 After bit 0 high phase: adc_sen high, sclk low, sdat low, frame_cnt+1 (wraps 255->0), go to GAP for 2*CLK_DIV cycles.
REQ-022 GAP exit: next init entry pending -> LOAD; last init entry -> init_done=1, IDLE; host frame -> IDLE.
REQ-023 In IDLE with start low and host_req high: host_ack pulses the same cycle as transition to LOAD with host fields.
REQ-024 start and host_req in the same IDLE cycle: start SHALL win; host request SHALL be served after init completes.
REQ-025 host_req SHALL NOT be acknowledged while busy; start SHALL be ignored while busy.
REQ-026 host_ack SHALL be at most one pulse per request; a new request needs host_req low for at least one cycle.
REQ-027 Idle bus levels SHALL be: adc_sen=1, adc_sclk=0, adc_sdat=0, adc_reset=0.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=IDLE, busy=0, init_done=0, host_ack=0, frame_cnt=0, idle bus levels; any frame in flight is aborted.
REQ-029 After rst_n rises, no frame SHALL start until a start or host_req is seen.

Verification (CLK_DIV=4, RST_LEN=8, RST_WAIT=16)
REQ-030 Start pulse: adc_reset high 8 cycles, first sen fall 16 cycles later, 4 frames of 128 cycles with 8-cycle gaps, sdat stream 0x0002, 0x3DE0, 0x41C0, 0x2503, init_done=1, frame_cnt=4.
REQ-031 host_req addr 0x41 data 0xA5 in IDLE: host_ack one pulse; frame 0x41A5 follows; busy drops after GAP; init_done unchanged.
REQ-032 start and host_req in the same cycle: 4 init frames, then host frame; host_ack asserts only after init_done rises.
REQ-033 host_req high mid-init: no ack until IDLE; exactly one ack; frame_cnt=5 at end.
REQ-034 rst_n pulled low during bit 7 of frame 2: outputs go to idle levels immediately, frame_cnt=0, no activity after release until start.
REQ-035 256 host frames: frame_cnt wraps to 0; sclk count per frame exactly 16.

Source files
------------

// File: rtl/adc_cfg_seq.sv
// ADC configuration sequencer: drives the ADC hardware reset, streams a fixed init
// table over a 3-wire serial bus, then serves runtime register writes from a host.
module adc_cfg_seq #(
  parameter int unsigned CLK_DIV  = 32,
  parameter int unsigned RST_LEN  = 256,
  parameter int unsigned RST_WAIT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       host_req,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ack,
  output logic       busy,
  output logic       init_done,
  output logic       adc_reset,
  output logic       adc_sen,
  output logic       adc_sclk,
  output logic       adc_sdat,
  output logic [7:0] frame_cnt
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned N_INIT  = 4;
  localparam int unsigned GAP_LEN = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX = (RST_LEN > RST_WAIT)
                                    ? ((RST_LEN > GAP_LEN) ? RST_LEN : GAP_LEN)
                                    : ((RST_WAIT > GAP_LEN) ? RST_WAIT : GAP_LEN);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_PULSE,
    S_RST_WAIT,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_e;

  function automatic logic [WORD_W-1:0] init_word(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    init_word = 16'h0002;
      2'd1:    init_word = 16'h3DE0;
      2'd2:    init_word = 16'h41C0;
      default: init_word = 16'h2503;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              half_q, half_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              init_mode_q, init_mode_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              ack_blk_q, ack_blk_d;
  logic              host_ack_q, host_ack_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;
  logic              adc_reset_q, adc_reset_d;
  logic              sen_q, sen_d;
  logic              sclk_q, sclk_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    half_d      = half_q;
    idx_d       = idx_q;
    init_mode_d = init_mode_q;
    hold_d      = hold_q;
    shreg_d     = shreg_q;
    ack_blk_d   = ack_blk_q & host_req;
    host_ack_d  = 1'b0;
    init_done_d = init_done_q;
    adc_reset_d = adc_reset_q;
    sen_d       = sen_q;
    sclk_d      = sclk_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RST_PULSE;
          cnt_d       = '0;
          idx_d       = '0;
          init_mode_d = 1'b1;
          init_done_d = 1'b0;
          adc_reset_d = 1'b1;
        end else if (host_req && !ack_blk_q) begin
          // A request is acked once; the host must drop req before the next one
          state_d     = S_LOAD;
          host_ack_d  = 1'b1;
          ack_blk_d   = 1'b1;
          init_mode_d = 1'b0;
          hold_d      = {host_addr, host_data};
        end
      end

      S_RST_PULSE: begin
        if (cnt_q == CNT_W'(RST_LEN - 1)) begin
          state_d     = S_RST_WAIT;
          cnt_d       = '0;
          adc_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_WAIT - 1)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_LOAD: begin
        shreg_d = init_mode_q ? init_word(idx_q) : hold_q;
        state_d = S_SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
        half_d  = 1'b0;
        sen_d   = 1'b0;
        sclk_d  = 1'b0;
      end

      S_SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b1;
          end else if (bit_q == BIT_W'(WORD_W - 1)) begin
            state_d     = S_GAP;
            half_d      = 1'b0;
            sen_d       = 1'b1;
            sclk_d      = 1'b0;
            shreg_d     = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            // Data moves only as sclk falls, giving the ADC a full half-period of setup
            half_d  = 1'b0;
            sclk_d  = 1'b0;
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
          cnt_d = '0;
          if (init_mode_q && (idx_q != IDX_W'(N_INIT - 1))) begin
            state_d = S_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            state_d     = S_IDLE;
            init_done_d = init_done_q | init_mode_q;
            init_mode_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      half_q      <= 1'b0;
      idx_q       <= '0;
      init_mode_q <= 1'b0;
      hold_q      <= '0;
      shreg_q     <= '0;
      ack_blk_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      adc_reset_q <= 1'b0;
      sen_q       <= 1'b1;
      sclk_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      half_q      <= half_d;
      idx_q       <= idx_d;
      init_mode_q <= init_mode_d;
      hold_q      <= hold_d;
      shreg_q     <= shreg_d;
      ack_blk_q   <= ack_blk_d;
      host_ack_q  <= host_ack_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      adc_reset_q <= adc_reset_d;
      sen_q       <= sen_d;
      sclk_q      <= sclk_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign host_ack  = host_ack_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign adc_reset = adc_reset_q;
  assign adc_sen   = sen_q;
  assign adc_sclk  = sclk_q;
  assign adc_sdat  = shreg_q[WORD_W-1];
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// Bench for adc_cfg_seq: a bus monitor decodes serial frames and timing, directed
// steps with random host payloads are checked against an expected-frame model.
module tb_adc_cfg_seq;

  localparam int unsigned CD = 4;
  localparam int unsigned RL = 8;
  localparam int unsigned RW = 16;
  localparam int FRAME_LEN  = 32 * CD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       host_req;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  logic       host_ack;
  logic       busy;
  logic       init_done;
  logic       adc_reset;
  logic       adc_sen;
  logic       adc_sclk;
  logic       adc_sdat;
  logic [7:0] frame_cnt;

  adc_cfg_seq #(.CLK_DIV(CD), .RST_LEN(RL), .RST_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .host_req(host_req),
    .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .busy(busy), .init_done(init_done), .adc_reset(adc_reset),
    .adc_sen(adc_sen), .adc_sclk(adc_sclk), .adc_sdat(adc_sdat),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int word;
    int len;
    int rises;
    int terr;
    int pre;
  } frame_t;

  frame_t fq[$];

  // Bus monitor state, sampled on the falling edge
  logic        p_sen = 1'b1, p_sclk = 1'b0, p_sdat = 1'b0, p_reset = 1'b0;
  logic        p_busy = 1'b0, p_ack = 1'b0;
  logic [15:0] sh = '0;
  bit          in_frame = 0;
  int idx = 0, rises_live = 0, terr = 0, pre = 0, gap = 0;
  int rst_hi = 0, rst_len_last = 0, frames_seen = 0, sen_low_cnt = 0;
  int idle_err = 0, ack_cnt = 0, ack_width_err = 0, ack_load_err = 0;
  logic last_ack_init = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; gap = 0; rst_hi = 0;
      p_sen = 1'b1; p_sclk = 1'b0; p_sdat = 1'b0; p_reset = 1'b0;
      p_busy = 1'b0; p_ack = 1'b0;
    end else begin
      if (host_ack) begin
        ack_cnt++;
        if (p_ack) ack_width_err++;
        if (!(busy && !p_busy)) ack_load_err++;
        last_ack_init = init_done;
      end
      if (adc_reset) begin
        rst_hi++;
        gap = 0;
      end else if (p_reset) begin
        rst_len_last = rst_hi;
        rst_hi = 0;
      end
      if (!adc_sen) begin
        sen_low_cnt++;
        if (!in_frame) begin
          in_frame = 1; idx = 0; rises_live = 0; sh = '0; terr = 0; pre = gap;
        end else begin
          idx++;
        end
        if (adc_sclk && !p_sclk) begin
          if (idx != (2 * rises_live + 1) * int'(CD)) terr++;
          if (idx > 0 && adc_sdat != p_sdat) terr++;
          sh = {sh[14:0], adc_sdat};
          rises_live++;
        end else if (!adc_sclk && p_sclk) begin
          if (idx != 2 * rises_live * int'(CD)) terr++;
        end else if (idx > 0 && adc_sdat != p_sdat) begin
          terr++;
        end
      end else begin
        if (in_frame) begin
          if (adc_sclk || adc_sdat || !p_sclk) terr++;
          fq.push_back('{word: int'(sh), len: idx + 1, rises: rises_live, terr: terr, pre: pre});
          frames_seen++;
          in_frame = 0;
          gap = 0;
        end else if (adc_sclk || adc_sdat) begin
          idle_err++;
        end
        if (!adc_reset) gap++;
      end
      p_sen = adc_sen; p_sclk = adc_sclk; p_sdat = adc_sdat;
      p_reset = adc_reset; p_busy = busy; p_ack = host_ack;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_ack(input int budget, output bit got);
    got = 0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (host_ack) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic pop_frame(input string tag, input int exp_word, input int exp_pre);
    frame_t f;
    chk({tag, "_present"}, 32'(fq.size() > 0), 1);
    if (fq.size() == 0) return;
    f = fq.pop_front();
    chk({tag, "_word"}, f.word, exp_word);
    chk({tag, "_len"}, f.len, FRAME_LEN);
    chk({tag, "_sclk_rises"}, f.rises, 16);
    chk({tag, "_timing"}, f.terr, 0);
    if (exp_pre >= 0) chk({tag, "_pre_gap"}, f.pre, exp_pre);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    fq.delete();
  endtask

  int  init_tbl[4] = '{16'h0002, 16'h3DE0, 16'h41C0, 16'h2503};
  int  exp_fc = 0;
  int  ack0, n, base, sl0;
  bit  got;
  logic [7:0] a, d;

  initial begin
    #2_000_000;
    $error("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; host_req = 1'b0; host_addr = '0; host_data = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_host_ack", 32'(host_ack), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_bus", 32'({adc_sen, adc_sclk, adc_sdat, adc_reset}), 32'h8);
    rst_n = 1'b1;
    repeat (50) tick();
    chk("no_auto_start", sen_low_cnt, 0);
    chk("no_auto_busy", 32'(busy), 0);

    // Full init sequence
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    wait_idle(3000);
    chk("reset_pulse_len", rst_len_last, RL);
    for (int i = 0; i < 4; i++) begin
      pop_frame($sformatf("init%0d", i), init_tbl[i], (i == 0) ? int'(RW) + 1 : 2 * int'(CD) + 1);
      exp_fc = (exp_fc + 1) % 256;
    end
    chk("init_done_set", 32'(init_done), 1);
    chk("init_frame_cnt", 32'(frame_cnt), exp_fc);

    // Host writes: one directed, then random payloads
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 8'h41 : 8'($urandom);
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      ack0 = ack_cnt;
      host_req = 1'b1; host_addr = a; host_data = d;
      wait_ack(50, got);
      chk("host_ack_seen", 32'(got), 1);
      host_req = 1'b0;
      wait_idle(1000);
      pop_frame($sformatf("host%0d", i), int'({a, d}), -1);
      exp_fc = (exp_fc + 1) % 256;
      chk("host_frame_cnt", 32'(frame_cnt), exp_fc);
      chk("host_init_done_kept", 32'(init_done), 1);
      chk("host_ack_once", ack_cnt - ack0, 1);
    end

    // start and host_req together: init first, host frame afterwards
    a = 8'($urandom); d = 8'($urandom);
    ack0 = ack_cnt;
    start = 1'b1; host_req = 1'b1; host_addr = a; host_data = d;
    tick();
    start = 1'b0;
    wait_ack(3000, got);
    chk("both_ack_seen", 32'(got), 1);
    chk("both_ack_after_init", 32'(last_ack_init), 1);
    host_req = 1'b0;
    wait_idle(1000);
    for (int i = 0; i < 4; i++) begin
      pop_frame($sformatf("both_init%0d", i), init_tbl[i], (i == 0) ? int'(RW) + 1 : 2 * int'(CD) + 1);
      exp_fc = (exp_fc + 1) % 256;
    end
    pop_frame("both_host", int'({a, d}), -1);
    exp_fc = (exp_fc + 1) % 256;
    chk("both_frame_cnt", 32'(frame_cnt), exp_fc);
    chk("both_ack_once", ack_cnt - ack0, 1);

    // host_req raised mid-init and held long past the ack; a second start while busy
    do_reset();
    pulse_start();
    repeat ($urandom_range(400, 100)) tick();
    a = 8'($urandom); d = 8'($urandom);
    ack0 = ack_cnt;
    host_req = 1'b1; host_addr = a; host_data = d;
    tick();
    pulse_start();
    wait_ack(3000, got);
    chk("mid_ack_seen", 32'(got), 1);
    repeat (170) tick();
    chk("mid_ack_once", ack_cnt - ack0, 1);
    host_req = 1'b0;
    wait_idle(1000);
    for (int i = 0; i < 4; i++)
      pop_frame($sformatf("mid_init%0d", i), init_tbl[i], -1);
    pop_frame("mid_host", int'({a, d}), -1);
    chk("mid_frame_cnt", 32'(frame_cnt), 5);
    chk("mid_no_extra_frame", fq.size(), 0);

    // Reset asserted during bit 7 of the second init frame
    do_reset();
    base = frames_seen;
    pulse_start();
    n = 0;
    while (!(frames_seen == base + 1 && in_frame && rises_live == 8) && n < 3000) begin
      tick();
      n++;
    end
    chk("reach_bit7", 32'(frames_seen == base + 1 && in_frame && rises_live == 8), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_bus", 32'({adc_sen, adc_sclk, adc_sdat, adc_reset}), 32'h8);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_frame_cnt", 32'(frame_cnt), 0);
    chk("abort_init_done", 32'(init_done), 0);
    tick(); tick();
    rst_n = 1'b1;
    sl0 = sen_low_cnt;
    repeat (100) tick();
    chk("abort_quiet", sen_low_cnt - sl0, 0);
    chk("abort_still_idle", 32'(busy), 0);
    pop_frame("abort_first", init_tbl[0], -1);
    chk("abort_partial_dropped", fq.size(), 0);

    // 256 host frames: counter wraps back to zero
    exp_fc = 0;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      host_req = 1'b1; host_addr = a; host_data = d;
      wait_ack(50, got);
      chk("wrap_ack_seen", 32'(got), 1);
      host_req = 1'b0;
      wait_idle(1000);
      pop_frame("wrap", int'({a, d}), -1);
      exp_fc = (exp_fc + 1) % 256;
      chk("wrap_frame_cnt", 32'(frame_cnt), exp_fc);
    end
    chk("wrap_to_zero", 32'(frame_cnt), 0);

    chk("ack_single_cycle", ack_width_err, 0);
    chk("ack_with_load", ack_load_err, 0);
    chk("idle_bus_levels", idle_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
